stream_accumulator: RTL and testbench



---
 rtl/stream_accum_pkg.sv | 12 +
 rtl/accum_sample_counter.sv | 36 +++
 rtl/adder_16bit.sv | 12 +
 rtl/stream_accumulator.sv | 114 +++++++++++
 tb/tb_stream_accumulator.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_accum_pkg.sv
// Shared constants and FSM state type for the stream accumulator.
package stream_accum_pkg;

  localparam int unsigned DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/accum_sample_counter.sv
// Per-batch sample counter: clears, increments on accept, stops at NUM_SAMPLES.
// o_rollover_flag marks the accept that completes the batch.
module accum_sample_counter #(
  parameter int unsigned NUM_SAMPLES = 8
) (
  input  logic                               clk,
  input  logic                               n_rst,
  input  logic                               i_clear,
  input  logic                               i_inc,
  output logic [$clog2(NUM_SAMPLES+1)-1:0]   o_count,
  output logic                               o_rollover_flag
);

  localparam int unsigned CW = $clog2(NUM_SAMPLES + 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_SAMPLES - 1);
  localparam logic [CW-1:0] TERM = CW'(NUM_SAMPLES);

  logic [CW-1:0] r_count;
  logic          w_at_term;

  assign w_at_term = (r_count == TERM);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && !w_at_term) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_count         = r_count;
  assign o_rollover_flag = i_inc && (r_count == LAST);

endmodule

// File: rtl/adder_16bit.sv
// Combinational 16-bit unsigned adder; overflow is the carry-out.
module adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        carry_in,
  output logic [15:0] sum,
  output logic        overflow
);

  assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {16'd0, carry_in};

endmodule

// File: rtl/stream_accumulator.sv
// Batch accumulator: sums NUM_SAMPLES handshaked operands through adder_16bit.
// Optional build macro STREAM_ACCUM_SATURATE_EN clamps the sum to FFFF on carry.
module stream_accumulator
  import stream_accum_pkg::*;
#(
  parameter int unsigned NUM_SAMPLES = 8
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic                             start,
  input  logic                             clear,
  input  logic                             data_valid,
  input  logic [DATA_WIDTH-1:0]            data_in,
  output logic                             data_ready,
  output logic [DATA_WIDTH-1:0]            accum_out,
  output logic                             overflow_flag,
  output logic [$clog2(NUM_SAMPLES+1)-1:0] sample_count,
  output logic                             done
);

  localparam int unsigned CW = $clog2(NUM_SAMPLES + 1);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_accum;
  logic                  r_overflow;
  logic                  r_done;

  logic [DATA_WIDTH-1:0] w_sum;
  logic                  w_carry;
  logic [DATA_WIDTH-1:0] w_next_accum;
  logic                  w_accept;
  logic                  w_batch_start;
  logic                  w_cnt_clear;
  logic                  w_rollover;
  logic [CW-1:0]         w_count;

  adder_16bit u_adder (
    .a        (r_accum),
    .b        (data_in),
    .carry_in (1'b0),
    .sum      (w_sum),
    .overflow (w_carry)
  );

  always_comb begin
    w_next_accum = w_sum;
`ifdef STREAM_ACCUM_SATURATE_EN
    if (w_carry) w_next_accum = '1;
`else
    w_next_accum = w_sum;
`endif
  end

  assign data_ready    = (r_state == ACCUM);
  assign w_accept      = data_valid & data_ready;
  // start only opens a new batch from IDLE or DONE; it is ignored mid-batch
  assign w_batch_start = start & (r_state != ACCUM);
  assign w_cnt_clear   = clear | w_batch_start;

  accum_sample_counter #(
    .NUM_SAMPLES (NUM_SAMPLES)
  ) u_counter (
    .clk             (clk),
    .n_rst           (n_rst),
    .i_clear         (w_cnt_clear),
    .i_inc           (w_accept),
    .o_count         (w_count),
    .o_rollover_flag (w_rollover)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= IDLE;
      r_accum    <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else if (clear) begin
      r_state    <= IDLE;
      r_accum    <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state    <= ACCUM;
            r_accum    <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
          end
        end
        ACCUM: begin
          if (w_accept) begin
            r_accum    <= w_next_accum;
            r_overflow <= r_overflow | w_carry;
            if (w_rollover) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign accum_out     = r_accum;
  assign overflow_flag = r_overflow;
  assign sample_count  = w_count;
  assign done          = r_done;

endmodule

// File: tb/tb_stream_accumulator.sv
// Self-checking bench for stream_accumulator with an arithmetic reference model.
module tb_stream_accumulator;

  localparam int NS = 8;
  localparam int CW = $clog2(NS + 1);
  localparam int VW = 16 + CW + 3;

`ifdef STREAM_ACCUM_SATURATE_EN
  localparam logic [15:0] EXP_OVF_SUM     = 16'hFFFF;
  localparam logic [15:0] EXP_RESTART_SUM = 16'hFFFF;
`else
  localparam logic [15:0] EXP_OVF_SUM     = 16'h1000;
  localparam logic [15:0] EXP_RESTART_SUM = 16'h0000;
`endif

  logic          clk = 1'b0;
  logic          n_rst;
  logic          start;
  logic          clear;
  logic          data_valid;
  logic [15:0]   data_in;
  logic          data_ready;
  logic [15:0]   accum_out;
  logic          overflow_flag;
  logic [CW-1:0] sample_count;
  logic          done;
  logic [VW-1:0] w_act;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned m_acc;
  bit          m_ovf;
  int          m_cnt;
  bit          m_active;

  stream_accumulator #(.NUM_SAMPLES(NS)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .start         (start),
    .clear         (clear),
    .data_valid    (data_valid),
    .data_in       (data_in),
    .data_ready    (data_ready),
    .accum_out     (accum_out),
    .overflow_flag (overflow_flag),
    .sample_count  (sample_count),
    .done          (done)
  );

  always #5 clk = ~clk;

  assign w_act = {accum_out, sample_count, overflow_flag, done, data_ready};

  function automatic void model_idle();
    m_acc = 0; m_ovf = 0; m_cnt = 0; m_active = 0;
  endfunction

  function automatic void model_start();
    m_acc = 0; m_ovf = 0; m_cnt = 0; m_active = 1;
  endfunction

  function automatic void model_accept(input logic [15:0] x);
    int unsigned t;
    t = m_acc + x;
    if (t > 32'h0000_FFFF) begin
      m_ovf = 1;
`ifdef STREAM_ACCUM_SATURATE_EN
      t = 32'h0000_FFFF;
`else
      t = t - 32'h0001_0000;
`endif
    end
    m_acc = t;
    m_cnt++;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [15:0]   a;
    logic [CW-1:0] c;
    logic          rdy;
    logic          dn;
    a   = m_acc[15:0];
    c   = m_cnt[CW-1:0];
    rdy = m_active && (m_cnt < NS);
    dn  = m_active && (m_cnt == NS);
    return {a, c, m_ovf, dn, rdy};
  endfunction

  // Applies one cycle of stimulus; the model advances by the rules seen before the edge.
  task automatic cycle(input bit s, input bit c, input bit v, input logic [15:0] d);
    if (c) model_idle();
    else if (!m_active) begin
      if (s) model_start();
    end else if (m_cnt == NS) begin
      if (s) model_start();
    end else if (v) model_accept(d);
    start = s; clear = c; data_valid = v; data_in = d;
    @(posedge clk);
    @(negedge clk);
    start = 0; clear = 0; data_valid = 0;
  endtask

  task automatic test_reset();
    model_idle();
    #12;
    @(negedge clk);
    n_checks++;
    if (w_act !== exp_vec()) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", w_act, exp_vec());
    end
    #2 n_rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (w_act !== exp_vec()) begin
      n_fail++; $display("FAIL reset_release_idle: got %h expected %h", w_act, exp_vec());
    end
  endtask

  task automatic test_basic();
    cycle(1, 0, 0, 16'h0);
    n_checks++;
    if (w_act !== exp_vec()) begin
      n_fail++; $display("FAIL basic_start: got %h expected %h", w_act, exp_vec());
    end
    for (int i = 1; i <= NS; i++) begin
      cycle(0, 0, 1, 16'(i));
      n_checks++;
      if (w_act !== exp_vec()) begin
        n_fail++; $display("FAIL basic_accept%0d: got %h expected %h", i, w_act, exp_vec());
      end
    end
    n_checks++;
    if ({accum_out, overflow_flag, done, data_ready} !== {16'h0024, 1'b0, 1'b1, 1'b0}
        || sample_count !== CW'(NS)) begin
      n_fail++;
      $display("FAIL basic_final: got acc=%h ovf=%b done=%b rdy=%b cnt=%0d expected acc=0024 ovf=0 done=1 rdy=0 cnt=%0d",
               accum_out, overflow_flag, done, data_ready, sample_count, NS);
    end
    cycle(0, 0, 1, 16'h1234);
    n_checks++;
    if (w_act !== exp_vec()) begin
      n_fail++; $display("FAIL done_hold: got %h expected %h", w_act, exp_vec());
    end
  endtask

  task automatic test_restart();
    logic [15:0] vals [NS];
    vals[0] = 16'hFFFF;
    vals[1] = 16'h0001;
    for (int i = 2; i < NS; i++) vals[i] = 16'h0000;
    cycle(1, 0, 0, 16'h0);
    n_checks++;
    if (accum_out !== 16'h0 || done !== 1'b0 || data_ready !== 1'b1 || w_act !== exp_vec()) begin
      n_fail++; $display("FAIL restart_clear: got %h expected %h", w_act, exp_vec());
    end
    for (int i = 0; i < NS; i++) begin
      cycle(0, 0, 1, vals[i]);
      n_checks++;
      if (w_act !== exp_vec()) begin
        n_fail++; $display("FAIL restart_accept%0d: got %h expected %h", i, w_act, exp_vec());
      end
    end
    n_checks++;
    if (accum_out !== EXP_RESTART_SUM || overflow_flag !== 1'b1 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_final: got acc=%h ovf=%b done=%b expected acc=%h ovf=1 done=1",
               accum_out, overflow_flag, done, EXP_RESTART_SUM);
    end
  endtask

  task automatic test_gaps();
    int next;
    int budget;
    next = 1;
    budget = 0;
    cycle(1, 0, 0, 16'h0);
    while (m_cnt < NS && budget < 40) begin
      if (budget % 2 == 1) cycle(budget % 4 == 1, 0, 0, 16'($urandom));
      else begin
        cycle(0, 0, 1, 16'(next));
        next++;
      end
      budget++;
      n_checks++;
      if (w_act !== exp_vec()) begin
        n_fail++; $display("FAIL gaps_cycle%0d: got %h expected %h", budget, w_act, exp_vec());
      end
    end
    n_checks++;
    if (m_cnt != NS || accum_out !== 16'h0024 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL gaps_final: got acc=%h done=%b after %0d cycles expected acc=0024 done=1",
               accum_out, done, budget);
    end
  endtask

  task automatic test_overflow();
    cycle(1, 0, 0, 16'h0);
    cycle(0, 0, 1, 16'hF000);
    cycle(0, 0, 1, 16'h2000);
    n_checks++;
    if (w_act !== exp_vec()) begin
      n_fail++; $display("FAIL ovf_carry: got %h expected %h", w_act, exp_vec());
    end
    for (int i = 0; i < NS - 2; i++) cycle(0, 0, 1, 16'h0000);
    n_checks++;
    if (accum_out !== EXP_OVF_SUM || overflow_flag !== 1'b1 || done !== 1'b1 || w_act !== exp_vec()) begin
      n_fail++;
      $display("FAIL ovf_final: got acc=%h ovf=%b done=%b expected acc=%h ovf=1 done=1",
               accum_out, overflow_flag, done, EXP_OVF_SUM);
    end
  endtask

  task automatic test_clear();
    cycle(1, 0, 0, 16'h0);
    for (int i = 1; i <= 3; i++) cycle(0, 0, 1, 16'(i));
    cycle(1, 1, 1, 16'h0010);
    n_checks++;
    if (accum_out !== 16'h0 || sample_count !== '0 || data_ready !== 1'b0 || w_act !== exp_vec()) begin
      n_fail++; $display("FAIL clear_prio: got %h expected %h", w_act, exp_vec());
    end
    cycle(0, 0, 1, 16'h0005);
    n_checks++;
    if (w_act !== exp_vec()) begin
      n_fail++; $display("FAIL idle_ignores_valid: got %h expected %h", w_act, exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    cycle(1, 0, 0, 16'h0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 16'h8000 + 16'(i));
    n_checks++;
    if (w_act !== exp_vec()) begin
      n_fail++; $display("FAIL mid_pre_reset: got %h expected %h", w_act, exp_vec());
    end
    #3 n_rst = 1'b0;
    model_idle();
    #1;
    n_checks++;
    if (w_act !== exp_vec()) begin
      n_fail++; $display("FAIL mid_async_reset: got %h expected %h", w_act, exp_vec());
    end
    @(negedge clk);
    #2 n_rst = 1'b1;
    @(negedge clk);
    cycle(1, 0, 0, 16'h0);
    cycle(0, 0, 1, 16'h0100);
    cycle(0, 0, 1, 16'h0023);
    n_checks++;
    if (accum_out !== 16'h0123 || sample_count !== CW'(2) || w_act !== exp_vec()) begin
      n_fail++; $display("FAIL mid_recovery: got %h expected %h", w_act, exp_vec());
    end
  endtask

  task automatic test_random();
    bit          s, c, v;
    logic [15:0] d;
    for (int i = 0; i < 600; i++) begin
      c = ($urandom_range(0, 49) == 0);
      s = ($urandom_range(0, 5) == 0);
      v = ($urandom_range(0, 2) != 0);
      d = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hE000, 16'hFFFF)) : 16'($urandom);
      cycle(s, c, v, d);
      n_checks++;
      if (w_act !== exp_vec()) begin
        n_fail++; $display("FAIL random_cycle%0d: got %h expected %h", i, w_act, exp_vec());
      end
    end
  endtask

  initial begin
    n_rst = 1'b0; start = 0; clear = 0; data_valid = 0; data_in = '0;
    model_idle();
    test_reset();
    test_basic();
    test_restart();
    test_gaps();
    test_overflow();
    test_clear();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
